// File: rtl/regfile_dump.sv
// ---------------------------------------------------------------------------
// regfile_dump
//
// The openMIPS architectural register file: 32 x 32-bit general-purpose
// registers. $0 is hard-wired to zero. The register file has:
//   - one write port, used by write-back;
//   - two combinational read ports, used by decode. Each read port bypasses
//     the write data forward when it reads the register being written.
//   - a debug dump engine. It streams every register, from index 0 up to 31,
//     over a valid/ready handshake.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   i_we           write enable from write-back
//   i_waddr        write address
//   i_wdata        write data
//   i_re1/i_re2    read port enables from decode
//   i_raddr1/2     read port addresses
//   o_rdata1/2     read port data (combinational)
//   i_dump_req     start a full dump (only looked at while idle)
//   o_dump_busy    dump engine is in SEND or DONE
//   o_dump_valid   dump beat valid
//   i_dump_ready   sink accepts the current beat
//   o_dump_addr    register index of the current beat
//   o_dump_data    live register value of the current beat
//   o_dump_done    one-cycle pulse after the final beat is accepted
// ---------------------------------------------------------------------------
module regfile_dump #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32   // must equal 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re1,
  input  logic [ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata1,
  input  logic              i_re2,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata2,
  input  logic              i_dump_req,
  output logic              o_dump_busy,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_dump_done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

  logic [DATA_W-1:0] r_regs [REG_NUM];
  state_t            r_state;
  state_t            w_stateNext;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idxNext;

  // Register storage. A reset clears every entry. Writes to $0 are
  // dropped, so entry 0 stays zero and nothing needs to mask it on a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read port 1. When the port reads the register being written in this
  // same cycle, it returns the incoming write data. This lets decode see
  // the write-back result without waiting a cycle.
  always_comb begin
    o_rdata1 = '0;
    if (!rst && (i_raddr1 != '0) && i_re1) begin
      if (i_we && (i_raddr1 == i_waddr)) begin
        o_rdata1 = i_wdata;
      end else begin
        o_rdata1 = r_regs[i_raddr1];
      end
    end
  end

  // Read port 2 uses the same priority as port 1. When both ports read the
  // same register, they therefore return the same value.
  always_comb begin
    o_rdata2 = '0;
    if (!rst && (i_raddr2 != '0) && i_re2) begin
      if (i_we && (i_raddr2 == i_waddr)) begin
        o_rdata2 = i_wdata;
      end else begin
        o_rdata2 = r_regs[i_raddr2];
      end
    end
  end

  // Dump engine state and beat index. A reset in the middle of a dump
  // aborts it at once, and the engine then issues no done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
    end
  end

  // Dump engine next state and outputs. The beat data is read live from
  // storage with no bypass. A write to the stalled index therefore shows up
  // one cycle later, and the sink takes whatever value is present on its
  // handshake cycle. The engine ignores a request while it is busy, and does
  // not queue one.
  always_comb begin
    w_stateNext  = r_state;
    w_idxNext    = r_idx;
    o_dump_busy  = 1'b0;
    o_dump_valid = 1'b0;
    o_dump_done  = 1'b0;
    o_dump_addr  = '0;
    o_dump_data  = '0;
    case (r_state)
      IDLE: begin
        if (i_dump_req) begin
          w_idxNext   = '0;
          w_stateNext = SEND;
        end
      end
      SEND: begin
        o_dump_busy  = 1'b1;
        o_dump_valid = 1'b1;
        o_dump_addr  = r_idx;
        o_dump_data  = r_regs[r_idx];
        if (i_dump_ready) begin
          if (r_idx == LAST_IDX) begin
            w_stateNext = DONE;
          end else begin
            w_idxNext = r_idx + 1'b1;
          end
        end
      end
      DONE: begin
        o_dump_busy = 1'b1;
        o_dump_done = 1'b1;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

endmodule
